// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: state encoding, default
// timeout, writeback field widths and the access-fault rule.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam int DEFAULT_MAX_WAIT = 16;
    localparam int WB_DATA_W        = 16;
    localparam int WB_REG_W         = 3;

    // A memory op faults when the word address is odd or when it asks to
    // read and write in the same instruction.
    function automatic logic access_fault(input logic addr_lsb,
                                          input logic rd,
                                          input logic wr);
        return addr_lsb | (rd & wr);
    endfunction

endpackage

// File: rtl/mem_req_timer.sv
// Outstanding-request timer. The count restarts at 1 on the cycle a request
// is issued, advances (saturating) while enabled, and flags expiry on the
// enabled cycle whose increment reaches MAX_WAIT.
module mem_req_timer
    import mem_stage_pkg::*;
#(
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);
    localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};

    logic [CW-1:0] count_r;

    // Count register: restart on clear, saturating increment when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= CNT_ONE;
        end else if (en && (count_r != CNT_SAT)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    // Expiry look-ahead so the state machine leaves on the reaching edge.
    always_comb begin
        expired = 1'b0;
        if (en && (count_r >= CNT_LAST)) begin
            expired = 1'b1;
        end else begin
            expired = 1'b0;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: turns execute results into single-word data-memory requests,
// stalls upstream while a request is in flight, and produces the registered
// MEM/WB bundle plus the alu_out_xm forwarding value.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid,
    input  logic [WB_DATA_W-1:0] ex_alu_out,
    input  logic [WB_DATA_W-1:0] ex_wdata,
    input  logic                 ex_mem_read,
    input  logic                 ex_mem_write,
    input  logic                 ex_wb_en,
    input  logic [WB_REG_W-1:0]  ex_wb_reg,
    output logic                 stall_out,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic [WB_DATA_W-1:0] mem_addr,
    output logic [WB_DATA_W-1:0] mem_din,
    input  logic [WB_DATA_W-1:0] mem_dout,
    input  logic                 mem_done,
    output logic [WB_DATA_W-1:0] alu_out_xm,
    output logic                 wb_valid,
    output logic [WB_DATA_W-1:0] wb_data,
    output logic                 wb_en,
    output logic [WB_REG_W-1:0]  wb_reg,
    output logic                 err
);

    state_t state_r;
    state_t next_state_s;

    logic accept_s;
    logic is_mem_s;
    logic fault_s;
    logic retire_s;
    logic timer_clear_s;
    logic timer_en_s;
    logic timer_expired_s;

    logic                 stall_r;
    logic                 mem_rd_r;
    logic                 mem_wr_r;
    logic [WB_DATA_W-1:0] req_addr_r;
    logic [WB_DATA_W-1:0] req_data_r;
    logic                 req_read_r;
    logic                 req_wb_en_r;
    logic [WB_REG_W-1:0]  req_wb_reg_r;
    logic [WB_DATA_W-1:0] alu_out_xm_r;
    logic                 wb_valid_r;
    logic [WB_DATA_W-1:0] wb_data_r;
    logic                 wb_en_r;
    logic [WB_REG_W-1:0]  wb_reg_r;
    logic                 err_r;

    assign accept_s = (state_r == ST_IDLE) && ex_valid;
    assign is_mem_s = ex_mem_read || ex_mem_write;
    assign fault_s  = access_fault(ex_alu_out[0], ex_mem_read, ex_mem_write);

    mem_req_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear_s),
        .en      (timer_en_s),
        .expired (timer_expired_s)
    );

    // Next-state, retire and timer control decode.
    always_comb begin
        next_state_s  = state_r;
        retire_s      = 1'b0;
        timer_clear_s = 1'b0;
        timer_en_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && is_mem_s) begin
                    if (fault_s) begin
                        next_state_s = ST_ERR;
                    end else begin
                        next_state_s  = ST_REQ;
                        timer_clear_s = 1'b1;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_done) begin
                    retire_s     = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_done) begin
                    retire_s     = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    timer_en_s = 1'b1;
                    if (timer_expired_s) begin
                        next_state_s = ST_ERR;
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end
            end
            ST_ERR: begin
                next_state_s = ST_ERR;
            end
            default: begin
                next_state_s = ST_ERR;
            end
        endcase
    end

    // State, stall, request strobes and the sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            stall_r  <= 1'b0;
            mem_rd_r <= 1'b0;
            mem_wr_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            stall_r  <= (next_state_s != ST_IDLE);
            mem_rd_r <= (next_state_s == ST_REQ) && ex_mem_read;
            mem_wr_r <= (next_state_s == ST_REQ) && ex_mem_write;
            err_r    <= err_r || (next_state_s == ST_ERR);
        end
    end

    // Request registers, captured only when a clean memory op is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr_r   <= {WB_DATA_W{1'b0}};
            req_data_r   <= {WB_DATA_W{1'b0}};
            req_read_r   <= 1'b0;
            req_wb_en_r  <= 1'b0;
            req_wb_reg_r <= {WB_REG_W{1'b0}};
        end else if (timer_clear_s) begin
            req_addr_r   <= ex_alu_out;
            req_data_r   <= ex_wdata;
            req_read_r   <= ex_mem_read;
            req_wb_en_r  <= ex_wb_en;
            req_wb_reg_r <= ex_wb_reg;
        end else begin
            req_addr_r   <= req_addr_r;
            req_data_r   <= req_data_r;
            req_read_r   <= req_read_r;
            req_wb_en_r  <= req_wb_en_r;
            req_wb_reg_r <= req_wb_reg_r;
        end
    end

    // Forwarding value tracks every accepted entry, faulting ones included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_xm_r <= {WB_DATA_W{1'b0}};
        end else if (accept_s) begin
            alu_out_xm_r <= ex_alu_out;
        end else begin
            alu_out_xm_r <= alu_out_xm_r;
        end
    end

    // Writeback bundle: ALU ops retire on acceptance, memory ops on done;
    // payload holds through bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_r <= 1'b0;
            wb_data_r  <= {WB_DATA_W{1'b0}};
            wb_en_r    <= 1'b0;
            wb_reg_r   <= {WB_REG_W{1'b0}};
        end else if (accept_s && !is_mem_s) begin
            wb_valid_r <= 1'b1;
            wb_data_r  <= ex_alu_out;
            wb_en_r    <= ex_wb_en;
            wb_reg_r   <= ex_wb_reg;
        end else if (retire_s) begin
            wb_valid_r <= 1'b1;
            wb_data_r  <= req_read_r ? mem_dout : req_addr_r;
            wb_en_r    <= req_wb_en_r;
            wb_reg_r   <= req_wb_reg_r;
        end else begin
            wb_valid_r <= 1'b0;
        end
    end

    assign stall_out  = stall_r;
    assign mem_rd     = mem_rd_r;
    assign mem_wr     = mem_wr_r;
    assign mem_addr   = req_addr_r;
    assign mem_din    = req_data_r;
    assign alu_out_xm = alu_out_xm_r;
    assign wb_valid   = wb_valid_r;
    assign wb_data    = wb_data_r;
    assign wb_en      = wb_en_r;
    assign wb_reg     = wb_reg_r;
    assign err        = err_r;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized
// run of ALU/load/store operations against a word-addressed memory model.
module tb_mem_stage;

    localparam int MAX_W = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [15:0] ex_alu_out;
    logic [15:0] ex_wdata;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_wb_en;
    logic [2:0]  ex_wb_reg;
    logic        stall_out;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic        mem_done;
    logic [15:0] alu_out_xm;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic        wb_en;
    logic [2:0]  wb_reg;
    logic        err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] mem_model [logic [15:0]];

    always #5 clk = ~clk;

    mem_stage #(.MAX_WAIT(MAX_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_alu_out   (ex_alu_out),
        .ex_wdata     (ex_wdata),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_wb_en     (ex_wb_en),
        .ex_wb_reg    (ex_wb_reg),
        .stall_out    (stall_out),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout),
        .mem_done     (mem_done),
        .alu_out_xm   (alu_out_xm),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data),
        .wb_en        (wb_en),
        .wb_reg       (wb_reg),
        .err          (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_lookup(input logic [15:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        else return {a[7:0], 8'h5A};
    endfunction

    task automatic drive_ex(input logic v, input logic rd, input logic wr,
                            input logic [15:0] alu, input logic [15:0] wd,
                            input logic we, input logic [2:0] rg);
        ex_valid     = v;
        ex_mem_read  = rd;
        ex_mem_write = wr;
        ex_alu_out   = alu;
        ex_wdata     = wd;
        ex_wb_en     = we;
        ex_wb_reg    = rg;
    endtask

    task automatic drive_junk();
        drive_ex(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 16'($urandom), 16'($urandom), 1'b1, 3'($urandom_range(0, 7)));
    endtask

    // Asserts reset off-edge, checks every output is cleared at once, then
    // releases it at the next falling edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        drive_ex(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd0);
        mem_done = 1'b0;
        #1;
        chk({tag, "_stall"},    32'(stall_out),  32'h0);
        chk({tag, "_mem_rd"},   32'(mem_rd),     32'h0);
        chk({tag, "_mem_wr"},   32'(mem_wr),     32'h0);
        chk({tag, "_wb_valid"}, 32'(wb_valid),   32'h0);
        chk({tag, "_err"},      32'(err),        32'h0);
        chk({tag, "_xm"},       32'(alu_out_xm), 32'h0);
        chk({tag, "_wb_data"},  32'(wb_data),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One operation from acceptance to retirement, starting just after a
    // falling edge with the stage idle. The bench answers as the memory,
    // raising done 'delay' cycles after the request cycle.
    task automatic run_op(input string tag, input logic rd, input logic wr,
                          input logic [15:0] alu, input logic [15:0] wd,
                          input logic we, input logic [2:0] rg, input int delay);
        logic [15:0] exp_data;
        exp_data = rd ? mem_lookup(alu) : alu;
        drive_ex(1'b1, rd, wr, alu, wd, we, rg);
        mem_done = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (rd || wr) begin
            for (int c = 0; c <= delay; c++) begin
                chk({tag, "_stall"},  32'(stall_out), 32'h1);
                chk({tag, "_wbv_lo"}, 32'(wb_valid),  32'h0);
                chk({tag, "_mem_rd"}, 32'(mem_rd),    32'((c == 0) && rd));
                chk({tag, "_mem_wr"}, 32'(mem_wr),    32'((c == 0) && wr));
                chk({tag, "_addr"},   32'(mem_addr),  32'(alu));
                chk({tag, "_din"},    32'(mem_din),   32'(wd));
                drive_junk();
                mem_done = (c == delay);
                mem_dout = rd ? exp_data : 16'($urandom);
                @(posedge clk);
                @(negedge clk);
            end
            mem_done = 1'b0;
            if (wr) mem_model[alu] = wd;
        end
        drive_ex(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd0);
        chk({tag, "_wb_valid"}, 32'(wb_valid),   32'h1);
        chk({tag, "_wb_data"},  32'(wb_data),    32'(exp_data));
        chk({tag, "_wb_en"},    32'(wb_en),      32'(we));
        chk({tag, "_wb_reg"},   32'(wb_reg),     32'(rg));
        chk({tag, "_xm"},       32'(alu_out_xm), 32'(alu));
        chk({tag, "_stall_lo"}, 32'(stall_out),  32'h0);
        chk({tag, "_no_err"},   32'(err),        32'h0);
    endtask

    initial begin
        int kind;
        logic [15:0] a;
        rst_n    = 1'b0;
        mem_done = 1'b0;
        mem_dout = 16'h0000;
        drive_ex(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd0);
        #2;
        chk("rst_stall",  32'(stall_out),  32'h0);
        chk("rst_mem_rd", 32'(mem_rd),     32'h0);
        chk("rst_mem_wr", 32'(mem_wr),     32'h0);
        chk("rst_addr",   32'(mem_addr),   32'h0);
        chk("rst_din",    32'(mem_din),    32'h0);
        chk("rst_xm",     32'(alu_out_xm), 32'h0);
        chk("rst_wbv",    32'(wb_valid),   32'h0);
        chk("rst_wbd",    32'(wb_data),    32'h0);
        chk("rst_wben",   32'(wb_en),      32'h0);
        chk("rst_wbreg",  32'(wb_reg),     32'h0);
        chk("rst_err",    32'(err),        32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back ALU pass-through, then one bubble.
        run_op("alu0", 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b1, 3'd3, 0);
        run_op("alu1", 1'b0, 1'b0, 16'h5678, 16'h0000, 1'b1, 3'd4, 0);
        @(posedge clk);
        @(negedge clk);
        chk("bubble_wbv",   32'(wb_valid), 32'h0);
        chk("bubble_wbd",   32'(wb_data),  32'h5678);
        chk("bubble_wbreg", 32'(wb_reg),   32'h4);

        // Load with done two cycles after the request, then a same-cycle store,
        // then a load answered on the last cycle before timeout.
        mem_model[16'h0040] = 16'hBEEF;
        run_op("load",     1'b1, 1'b0, 16'h0040, 16'h1111, 1'b1, 3'd5, 2);
        run_op("store",    1'b0, 1'b1, 16'h0100, 16'hA5A5, 1'b0, 3'd2, 0);
        run_op("load_max", 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 3'd6, MAX_W - 1);

        // Randomized mix against the memory model.
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 2));
            a    = 16'(16'h0200 + 16'($urandom_range(0, 7)) * 16'd2);
            if (kind == 0)
                run_op("rnd_alu", 1'b0, 1'b0, 16'($urandom), 16'($urandom), 1'b1,
                       3'($urandom_range(0, 7)), 0);
            else if (kind == 1)
                run_op("rnd_load", 1'b1, 1'b0, a, 16'($urandom), 1'b1,
                       3'($urandom_range(0, 7)), int'($urandom_range(0, MAX_W - 1)));
            else
                run_op("rnd_store", 1'b0, 1'b1, a, 16'($urandom), 1'b0,
                       3'($urandom_range(0, 7)), int'($urandom_range(0, MAX_W - 1)));
        end

        // Misaligned load: no request, sticky error, later done ignored.
        drive_ex(1'b1, 1'b1, 1'b0, 16'h0003, 16'h0000, 1'b1, 3'd1);
        @(posedge clk);
        @(negedge clk);
        drive_ex(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd0);
        chk("mis_xm", 32'(alu_out_xm), 32'h0003);
        for (int k = 0; k < 3; k++) begin
            chk("mis_err",   32'(err),       32'h1);
            chk("mis_rd",    32'(mem_rd),    32'h0);
            chk("mis_stall", 32'(stall_out), 32'h1);
            chk("mis_wbv",   32'(wb_valid),  32'h0);
            mem_done = 1'b1;
            drive_junk();
            @(posedge clk);
            @(negedge clk);
        end
        do_reset("rst_err");

        // Read and write together on an aligned address is also a fault.
        drive_ex(1'b1, 1'b1, 1'b1, 16'h0020, 16'h0000, 1'b1, 3'd1);
        @(posedge clk);
        @(negedge clk);
        drive_ex(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd0);
        chk("rw_err", 32'(err),    32'h1);
        chk("rw_rd",  32'(mem_rd), 32'h0);
        chk("rw_wr",  32'(mem_wr), 32'h0);

        // Reset while a request strobe is high.
        do_reset("rst_err2");
        drive_ex(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1, 3'd1);
        @(posedge clk);
        @(negedge clk);
        chk("req_rd_hi", 32'(mem_rd), 32'h1);
        #2;
        do_reset("rst_req");

        // Timeout: no done, error exactly MAX_W edges after the request starts.
        drive_ex(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 3'd2);
        @(posedge clk);
        @(negedge clk);
        drive_ex(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd0);
        chk("to_err_req", 32'(err), 32'h0);
        for (int k = 1; k <= MAX_W; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("to_err_edge", 32'(err),      32'((k == MAX_W)));
            chk("to_wbv",      32'(wb_valid), 32'h0);
        end
        for (int k = 0; k < 2; k++) begin
            mem_done = 1'b1;
            mem_dout = 16'hDEAD;
            @(posedge clk);
            @(negedge clk);
            chk("to_late_err",   32'(err),       32'h1);
            chk("to_late_wbv",   32'(wb_valid),  32'h0);
            chk("to_late_stall", 32'(stall_out), 32'h1);
        end
        mem_done = 1'b0;
        do_reset("rst_to");

        // Reset mid-WAIT, then a fresh ALU op retires one cycle after acceptance.
        drive_ex(1'b1, 1'b1, 1'b0, 16'h0080, 16'h0000, 1'b1, 3'd7);
        @(posedge clk);
        @(negedge clk);
        drive_ex(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd0);
        @(posedge clk);
        @(negedge clk);
        chk("wait_stall", 32'(stall_out), 32'h1);
        chk("wait_rd",    32'(mem_rd),    32'h0);
        #2;
        do_reset("rst_wait");
        run_op("post_rst", 1'b0, 1'b0, 16'h0001, 16'h0000, 1'b1, 3'd1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage directly downstream of execute. Consumes the ALU result (address or value) and the forwarded store data.
- Issues single-word requests to a multi-cycle data memory through a request/done handshake and stalls upstream while the access is in flight.
- Produces the registered MEM/WB writeback bundle, plus the alu_out_xm forwarding value that feeds back to execute.

Parameters:
- MAX_WAIT, 16: cycles a request may stay outstanding (REQ+WAIT) before it is declared timed out; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute presents a valid instruction.
- ex_alu_out  in  16  ALU result; byte address when a memory op.
- ex_wdata  in  16  store data (forwarded reg2 value).
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store.
- ex_wb_en  in  1  instruction writes the register file.
- ex_wb_reg  in  3  destination register.
- stall_out  out  1  upstream must hold its outputs; an entry is accepted only on an edge where ex_valid=1 and stall_out=0.
- mem_rd  out  1  read request strobe.
- mem_wr  out  1  write request strobe.
- mem_addr  out  16  request address.
- mem_din  out  16  store data.
- mem_dout  in  16  load data, valid with mem_done.
- mem_done  in  1  access complete.
- alu_out_xm  out  16  registered ex_alu_out of the last accepted entry (forwarding source).
- wb_valid  out  1  one-cycle pulse per retired instruction.
- wb_data  out  16  writedata: mem_dout for loads, ALU result otherwise.
- wb_en  out  1  registered ex_wb_en of the retiring instruction.
- wb_reg  out  3  registered ex_wb_reg of the retiring instruction.
- err  out  1  sticky fault (misaligned, read+write together, or timeout).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, and every output is 0. This includes mem_rd/mem_wr, which deassert immediately even mid-access.
- States are IDLE, REQ, WAIT, ERR. stall_out = (state != IDLE).
- IDLE, entry accepted, no memory op:
  - Next edge: wb_valid=1, wb_data=ex_alu_out, wb_en/wb_reg registered, alu_out_xm=ex_alu_out.
  - Latency 1; back-to-back acceptance allowed every cycle.
- IDLE, entry accepted, memory op, fault case: if ex_alu_out[0]=1 (misaligned), or ex_mem_read and ex_mem_write are both 1, go to ERR. No request is issued.
- IDLE, entry accepted, memory op, normal case: latch addr, data, op and wb fields into request registers; alu_out_xm=ex_alu_out; go to REQ; counter=1.
- REQ:
  - mem_rd or mem_wr=1 for this cycle only; mem_addr and mem_din driven from the request registers.
  - If mem_done=1 in this cycle: retire at the edge and go to IDLE. Otherwise go to WAIT.
- WAIT:
  - mem_rd=mem_wr=0; mem_addr and mem_din held.
  - mem_done=1: retire and go to IDLE.
  - Otherwise the counter increments. If the counter reaches MAX_WAIT without done, go to ERR.
- Retire:
  - wb_valid=1 for one cycle.
  - wb_data=mem_dout for a load. For a store, wb_data=the request address and wb_en is passed through (the decoder supplies 0).
- ERR: err=1 sticky until reset; stall_out=1; wb_valid=0; mem_rd=mem_wr=0; mem_done is ignored.
- wb_valid=0 on every cycle in which nothing retires (bubble); wb_data, wb_en and wb_reg hold their last values.
- mem_done in IDLE or ERR is ignored.
- ex_* inputs while stall_out=1 are ignored.
- The counter is $clog2(MAX_WAIT+1) bits wide and saturates (no wrap).
- Arithmetic: none beyond the counter. Address and data are passed unmodified, 16-bit.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, ERR=2'd3);
  - the default MAX_WAIT constant;
  - the wb bundle field widths (data 16, reg 3).
- One natural sub-module: mem_req_timer.
  - Inputs: clear, count enable.
  - Output: expired when count reaches MAX_WAIT.
  - Same clk/rst_n.

Test Plan:
- ALU pass-through: accept alu_out=0x1234, wb_en=1, wb_reg=3, then next op 0x5678 → wb_valid pulses on two consecutive cycles with wb_data 0x1234 then 0x5678; stall_out=0 throughout.
- Load, done 2 cycles after REQ, mem_dout=0xBEEF, addr 0x0040:
  - mem_rd=1 for exactly one cycle with mem_addr=0x0040.
  - stall_out=1 for 3 cycles.
  - Then wb_valid=1, wb_data=0xBEEF, wb_reg as latched.
- Store, addr 0x0100, data 0xA5A5, mem_done same cycle as REQ → mem_wr one cycle, mem_din=0xA5A5, one stall cycle, wb_valid=1 with wb_en=0.
- Misaligned load addr 0x0003 → mem_rd never asserts; err=1 from the next edge, stays 1; stall_out=1; wb_valid stays 0.
- MAX_WAIT=4, load with mem_done never asserted → err rises at the edge where the counter reaches 4; a later mem_done=1 has no effect.
- Reset mid-WAIT (rst_n low between edges):
  - mem_rd, mem_wr, stall_out and wb_valid go to 0 immediately.
  - After release, an ALU op 0x0001 retires one cycle after acceptance.
